reorder_buffer: RTL

Two-wide in-order reorder buffer sitting directly downstream of the rename stage. It accepts up to two renamed instructions per cycle, tracks their completion from execution, and retires up to two per cycle in program order. On retirement it returns the previous physical mapping of each destination to the freelist via `released_tag*` and `comnum`.

---
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: two-wide in-order reorder buffer placed after rename.
// Accepts up to two renamed instructions per cycle, records completions
// from execution and retires up to two per cycle in program order. Each
// retirement hands the previous physical mapping back to the freelist.
module reorder_buffer #(
  parameter int ENTRY_NUM   = 16,
  parameter int ROB_SEL     = 4,
  parameter int PHY_REG_SEL = 6,
  parameter int REG_SEL     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dp1_valid,
  input  logic                   dp2_valid,
  input  logic                   dp1_wr_reg,
  input  logic                   dp2_wr_reg,
  input  logic [REG_SEL-1:0]     dp1_dst,
  input  logic [REG_SEL-1:0]     dp2_dst,
  input  logic [PHY_REG_SEL-1:0] dp1_phy_dst,
  input  logic [PHY_REG_SEL-1:0] dp2_phy_dst,
  input  logic [PHY_REG_SEL-1:0] dp1_phy_ori_dst,
  input  logic [PHY_REG_SEL-1:0] dp2_phy_ori_dst,
  output logic                   dp_ready,
  output logic [ROB_SEL-1:0]     dp1_tag,
  output logic [ROB_SEL-1:0]     dp2_tag,
  input  logic                   cmp1_valid,
  input  logic                   cmp2_valid,
  input  logic [ROB_SEL-1:0]     cmp1_tag,
  input  logic [ROB_SEL-1:0]     cmp2_tag,
  output logic [1:0]             comnum,
  output logic [PHY_REG_SEL-1:0] released_tag1,
  output logic [PHY_REG_SEL-1:0] released_tag2,
  output logic                   released_tag1_val,
  output logic                   released_tag2_val,
  output logic [REG_SEL-1:0]     com1_dst,
  output logic [REG_SEL-1:0]     com2_dst,
  output logic [PHY_REG_SEL-1:0] com1_phy_dst,
  output logic [PHY_REG_SEL-1:0] com2_phy_dst,
  output logic                   empty
);

  localparam int CW = ROB_SEL + 1;

  // Pointer / occupancy state
  logic [ROB_SEL-1:0]   head_q, head_d;
  logic [ROB_SEL-1:0]   tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  // Per-entry status bits
  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [ENTRY_NUM-1:0] done_q, done_d;

  // Per-entry payload (only meaningful while valid)
  logic [ENTRY_NUM-1:0]   wr_reg_q;
  logic [REG_SEL-1:0]     dst_q     [ENTRY_NUM];
  logic [PHY_REG_SEL-1:0] phy_dst_q [ENTRY_NUM];
  logic [PHY_REG_SEL-1:0] phy_ori_q [ENTRY_NUM];

  logic                 dp1_acc_s;
  logic                 dp2_acc_s;
  logic [ROB_SEL-1:0]   head1_s;
  logic                 c0_s;
  logic                 c1_s;

  // Dispatch acceptance, entry tags and commit decision from registered state
  always_comb begin
    dp_ready  = (count_q <= CW'(ENTRY_NUM - 2));
    dp1_acc_s = dp_ready & dp1_valid;
    dp2_acc_s = dp_ready & dp2_valid;
    dp1_tag   = tail_q;
    dp2_tag   = tail_q + ROB_SEL'(dp1_valid);
    head1_s   = head_q + ROB_SEL'(1);
    c0_s      = valid_q[head_q] & done_q[head_q];
    c1_s      = c0_s & valid_q[head1_s] & done_q[head1_s];
    comnum    = 2'(c0_s) + 2'(c1_s);
    empty     = (count_q == CW'(0));
  end

  // Retirement outputs, zeroed for slots that are not committing
  always_comb begin
    released_tag1     = c0_s ? phy_ori_q[head_q]  : {PHY_REG_SEL{1'b0}};
    released_tag2     = c1_s ? phy_ori_q[head1_s] : {PHY_REG_SEL{1'b0}};
    released_tag1_val = c0_s & wr_reg_q[head_q];
    released_tag2_val = c1_s & wr_reg_q[head1_s];
    com1_dst          = c0_s ? dst_q[head_q]      : {REG_SEL{1'b0}};
    com2_dst          = c1_s ? dst_q[head1_s]     : {REG_SEL{1'b0}};
    com1_phy_dst      = c0_s ? phy_dst_q[head_q]  : {PHY_REG_SEL{1'b0}};
    com2_phy_dst      = c1_s ? phy_dst_q[head1_s] : {PHY_REG_SEL{1'b0}};
  end

  // Next-state of status bits and pointers: completion, commit, dispatch
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    // completions only land on live entries; equal tags simply OR together
    done_d[cmp1_tag] = done_d[cmp1_tag] | (cmp1_valid & valid_q[cmp1_tag]);
    done_d[cmp2_tag] = done_d[cmp2_tag] | (cmp2_valid & valid_q[cmp2_tag]);
    // committed entries are freed
    valid_d[head_q]  = valid_d[head_q]  & ~c0_s;
    done_d[head_q]   = done_d[head_q]   & ~c0_s;
    valid_d[head1_s] = valid_d[head1_s] & ~c1_s;
    done_d[head1_s]  = done_d[head1_s]  & ~c1_s;
    // dispatched entries start live and not done; they never overlap a
    // committing entry because dispatch is refused when the buffer is full
    valid_d[dp1_tag] = valid_d[dp1_tag] | dp1_acc_s;
    done_d[dp1_tag]  = done_d[dp1_tag]  & ~dp1_acc_s;
    valid_d[dp2_tag] = valid_d[dp2_tag] | dp2_acc_s;
    done_d[dp2_tag]  = done_d[dp2_tag]  & ~dp2_acc_s;

    head_d  = head_q + ROB_SEL'(comnum);
    tail_d  = tail_q + ROB_SEL'(dp1_acc_s) + ROB_SEL'(dp2_acc_s);
    count_d = count_q + CW'(dp1_acc_s) + CW'(dp2_acc_s) - CW'(comnum);
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {ROB_SEL{1'b0}};
      tail_q  <= {ROB_SEL{1'b0}};
      count_q <= {CW{1'b0}};
      valid_q <= {ENTRY_NUM{1'b0}};
      done_q  <= {ENTRY_NUM{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload capture on accepted dispatch; contents are ignored while invalid
  always_ff @(posedge clk) begin
    if (dp1_acc_s) begin
      wr_reg_q[dp1_tag]  <= dp1_wr_reg;
      dst_q[dp1_tag]     <= dp1_dst;
      phy_dst_q[dp1_tag] <= dp1_phy_dst;
      phy_ori_q[dp1_tag] <= dp1_phy_ori_dst;
    end
    if (dp2_acc_s) begin
      wr_reg_q[dp2_tag]  <= dp2_wr_reg;
      dst_q[dp2_tag]     <= dp2_dst;
      phy_dst_q[dp2_tag] <= dp2_phy_dst;
      phy_ori_q[dp2_tag] <= dp2_phy_ori_dst;
    end
  end

endmodule
